// File: rtl/onehot_scan_decoder_if.sv
// Bus bundle for onehot_scan_decoder: control/address inputs and registered
// decode outputs. The master drives the controls, the slave is the decoder.
interface onehot_scan_decoder_if #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << ADDR_W;

  logic               en;
  logic               mode;
  logic               load;
  logic [ADDR_W-1:0]  a;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   bcode;
  logic [ADDR_W-1:0]  idx;
  logic               wrap;

  modport master (
    output en, mode, load, a, dwell,
    input  bcode, idx, wrap
  );

  modport slave (
    input  en, mode, load, a, dwell,
    output bcode, idx, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and load, plus an optional
// auto-scan mode that steps the index at a programmable dwell rate.
// Optional feature macro: ONEHOT_SCAN_DECODER_SCAN_EN (SCAN state, dwell
// counter, wrap pulse). Without it, mode/dwell are ignored and wrap is 0.
module onehot_scan_decoder #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_scan_decoder_if.slave bus
);
  localparam int OUT_W = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // The operating state has no memory of its own: it is re-derived from
  // en/mode every cycle and selects what the coming edge does.
  state_e state;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0]  bcode_q, bcode_d;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  localparam logic [ADDR_W-1:0] IDX_MAX = '1;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
`endif

  // Decode the operating state for this cycle from en/mode.
  always_comb begin
    state = ST_IDLE;
    if (bus.en) begin
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      state = bus.mode ? ST_SCAN : ST_DIRECT;
`else
      state = ST_DIRECT;
`endif
    end
  end

  // Next index / counter / wrap with priority load > scan advance > hold.
  always_comb begin
    idx_d = idx_q;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    cnt_d  = '0;
    wrap_d = 1'b0;
`endif
    if (bus.load) begin
      idx_d = bus.a;
    end
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    else if (state == ST_SCAN) begin
      // Equality compare only: a counter already past a lowered dwell runs
      // through its natural overflow before it can match again.
      if (cnt_q == bus.dwell) begin
        idx_d  = idx_q + ADDR_W'(1);
        wrap_d = (idx_q == IDX_MAX);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
`endif
  end

  // One-hot of the next index, or all-zero while disabled.
  always_comb begin
    bcode_d = '0;
    if (state != ST_IDLE) bcode_d[idx_d] = 1'b1;
  end

  // State registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      bcode_q <= '0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      bcode_q <= bcode_d;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign bus.bcode = bcode_q;
  assign bus.idx   = idx_q;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  assign bus.wrap  = wrap_q;
`else
  assign bus.wrap  = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench for onehot_scan_decoder: directed vector table,
// hand-written scan/collision/reset sequences, and randomized traffic
// compared against a behavioural model.
module tb_onehot_scan_decoder;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int OW = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  onehot_scan_decoder_if #(.ADDR_W(AW), .DWELL_W(DW)) bus ();

  onehot_scan_decoder #(.ADDR_W(AW), .DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: index plus elapsed cycles in the current dwell period.
  int   m_idx = 0;
  int   m_el  = 0;
  logic m_wrap = 1'b0;
  int   m_bcode = 0;

  typedef struct {
    logic          en;
    logic [AW-1:0] a;
    logic [OW-1:0] eb;
    logic [AW-1:0] ei;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic model_step();
    m_wrap = 1'b0;
    if (bus.load) begin
      m_idx = int'(bus.a);
      m_el  = 0;
    end
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    else if (bus.en && bus.mode) begin
      if (m_el == int'(bus.dwell)) begin
        m_wrap = (m_idx == OW - 1);
        m_idx  = (m_idx + 1) % OW;
        m_el   = 0;
      end else begin
        m_el = (m_el + 1) % (1 << DW);
      end
    end
`endif
    else begin
      m_el = 0;
    end
    m_bcode = bus.en ? (1 << m_idx) : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3;
    m_idx = 0; m_el = 0; m_wrap = 1'b0; m_bcode = 0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b1, AW'(i), OW'(1 << i), AW'(i)};
      tbl[8 + i] = '{1'b0, AW'(i), 8'h00,       AW'(i)};
    end

    bus.en = 1'b0; bus.mode = 1'b0; bus.load = 1'b0; bus.a = '0; bus.dwell = '0;

    // Reset and enable
    do_reset();
    chk("rst_bcode", 32'(bus.bcode), 32'h0);
    chk("rst_idx",   32'(bus.idx),   32'h0);
    chk("rst_wrap",  32'(bus.wrap),  32'h0);
    step();
    chk("en0_bcode", 32'(bus.bcode), 32'h0);
    bus.en = 1'b1;
    step();
    chk("en1_bcode", 32'(bus.bcode), 32'h01);

    // Direct decode table, enabled then disabled
    for (int i = 0; i < 16; i++) begin
      bus.en = tbl[i].en; bus.load = 1'b1; bus.a = tbl[i].a;
      step();
      chk($sformatf("tbl%0d_bcode", i), 32'(bus.bcode), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_idx", i),   32'(bus.idx),   32'(tbl[i].ei));
    end
    bus.load = 1'b0;

    // Asynchronous reset mid-dwell
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 8'd5; bus.load = 1'b1; bus.a = 3'd5;
    step();
    bus.load = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcode", 32'(bus.bcode), 32'h0);
    chk("arst_idx",   32'(bus.idx),   32'h0);
    chk("arst_wrap",  32'(bus.wrap),  32'h0);
    m_idx = 0; m_el = 0; m_wrap = 1'b0; m_bcode = 0;
    @(negedge clk) rst_n = 1'b1;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    begin
      logic [7:0] exp_b [7];
      logic       exp_w [7];
      exp_b = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      // Scan with dwell=2 from index 6
      bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 8'd2; bus.load = 1'b1; bus.a = 3'd6;
      for (int k = 0; k < 7; k++) begin
        step();
        bus.load = 1'b0;
        chk($sformatf("scan2_b%0d", k), 32'(bus.bcode), 32'(exp_b[k]));
        chk($sformatf("scan2_w%0d", k), 32'(bus.wrap),  32'(exp_w[k]));
      end
    end

    // Load of 0 colliding with an advance from 7
    bus.dwell = 8'd1; bus.load = 1'b1; bus.a = 3'd7;
    step();
    bus.load = 1'b0;
    step();
    chk("col_pre_idx", 32'(bus.idx), 32'd7);
    bus.load = 1'b1; bus.a = 3'd0;
    step();
    bus.load = 1'b0;
    chk("col_idx",  32'(bus.idx),  32'd0);
    chk("col_wrap", 32'(bus.wrap), 32'd0);
    step();
    chk("col_hold_idx", 32'(bus.idx), 32'd0);
    step();
    chk("col_adv_idx",  32'(bus.idx), 32'd1);
    chk("col_adv_wrap", 32'(bus.wrap), 32'd0);

    // dwell=0 sweep: advance every cycle, one wrap per full sweep
    bus.dwell = 8'd0; bus.load = 1'b1; bus.a = 3'd0;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= OW; k++) begin
      step();
      chk($sformatf("sw0_idx%0d", k),  32'(bus.idx),  32'(k % OW));
      chk($sformatf("sw0_wrap%0d", k), 32'(bus.wrap), 32'(k == OW));
    end
`else
    // Without scan support, mode/dwell must not move the index
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 8'd0; bus.load = 1'b1; bus.a = 3'd3;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("noscan_idx%0d", k),  32'(bus.idx),  32'd3);
      chk($sformatf("noscan_wrap%0d", k), 32'(bus.wrap), 32'd0);
    end
`endif

    // Randomized traffic against the model
    bus.load = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.dwell = 8'd1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.load = ($urandom_range(0, 9) == 0);
      bus.a    = AW'($urandom_range(0, OW - 1));
      if ($urandom_range(0, 24) == 0) bus.dwell = DW'($urandom_range(0, 3));
      step();
      chk($sformatf("rnd%0d_bcode", c), 32'(bus.bcode), 32'(m_bcode));
      chk($sformatf("rnd%0d_idx", c),   32'(bus.idx),   32'(m_idx));
      chk($sformatf("rnd%0d_wrap", c),  32'(bus.wrap),  32'(m_wrap));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
